muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq_pkg.sv | 37 +++
 rtl/muldiv_div_step.sv | 36 +++
 rtl/muldiv_seq.sv | 211 +++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_seq_pkg
//   Shared definitions for the RV32M multi-cycle multiply/divide sequencer:
//   func3 codes of the M extension, FSM state encodings and operand
//   signedness decode helpers.
// -----------------------------------------------------------------------------
package muldiv_seq_pkg;

  // RV32M func3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MD_ST_IDLE = 3'd0,
    MD_ST_MUL  = 3'd1,
    MD_ST_DIV  = 3'd2,
    MD_ST_FIX  = 3'd3,
    MD_ST_DONE = 3'd4
  } md_state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
//   One combinational restoring-division step: shift the next dividend bit
//   (MSB of i_quo) into the partial remainder, subtract the divisor if it
//   fits, and shift the resulting quotient bit into the bottom of i_quo.
// Ports
//   i_rem      partial remainder in
//   i_quo      dividend bits still to consume / quotient bits produced so far
//   i_divisor  divisor magnitude
//   o_rem      partial remainder out
//   o_quo      updated dividend/quotient register
// -----------------------------------------------------------------------------
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shifted;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  assign w_shifted = {i_rem, i_quo[XLEN-1]};
  assign w_fits    = (w_shifted >= {1'b0, i_divisor});
  // When the divisor fits, the true difference is below the divisor, so the
  // low XLEN bits of the modular subtraction are exact.
  assign w_diff    = w_shifted[XLEN-1:0] - i_divisor;

  assign o_rem = w_fits ? w_diff : w_shifted[XLEN-1:0];
  assign o_quo = {i_quo[XLEN-2:0], w_fits};

endmodule

// File: rtl/muldiv_seq.sv
// -----------------------------------------------------------------------------
// muldiv_seq
//   Multi-cycle sequencer for RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/
//   REMU). Operands are latched as magnitudes on accept; shift-add multiply or
//   restoring divide runs one bit per clock; FIX applies the recorded sign.
//   Special divides (x/0, INT_MIN/-1) skip iteration and go straight to FIX.
// Build option
//   MULDIV_FAST_MUL_EN : multiply ops use a single-cycle XLENxXLEN product and
//                        go IDLE -> FIX directly; the MUL state is never used.
// Ports
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   op request, accepted only in IDLE or DONE and not during flush
//   flush   kill in-flight op; result keeps its previous value
//   func3   M-op select
//   op_a    rs1, sampled on the accepting edge
//   op_b    rs2, sampled on the accepting edge
//   busy    registered, high in MUL/DIV/FIX
//   stall   combinational: accepted start or busy
//   done    registered one-cycle pulse, result valid
//   result  registered result, held until a later op completes
// -----------------------------------------------------------------------------
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int                PW          = 2 * XLEN;
  localparam logic [XLEN-1:0]   LP_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LP_CNT_LAST = CNT_W'(XLEN);

  md_state_e       r_state;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_spec;
  logic [XLEN-1:0] r_hi;   // product high half / partial remainder
  logic [XLEN-1:0] r_lo;   // multiplier+product low half / dividend+quotient
  logic [XLEN-1:0] r_b;    // multiplicand / divisor magnitude

  // ---------------- accept-side decode ----------------
  logic            w_accept;
  logic            w_sa, w_sb, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_is_div, w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0] w_spec_val;
  logic [XLEN-1:0] w_load_hi, w_load_lo;
  md_state_e       w_acc_state;

  assign w_accept = start & ~flush & ((r_state == MD_ST_IDLE) || (r_state == MD_ST_DONE));

  assign w_sa    = op_a[XLEN-1] & op_a_signed(func3);
  assign w_sb    = op_b[XLEN-1] & op_b_signed(func3);
  assign w_a_mag = w_sa ? -op_a : op_a;
  assign w_b_mag = w_sb ? -op_b : op_b;
  // Unsigned ops have w_sa = w_sb = 0, so only REM needs its own rule.
  assign w_neg   = (func3 == F3_REM) ? w_sa : (w_sa ^ w_sb);

  assign w_is_div   = func3[2];
  assign w_div_zero = (op_b == '0);
  assign w_div_ovf  = ((func3 == F3_DIV) || (func3 == F3_REM)) && (op_a == LP_MIN) && (op_b == '1);
  assign w_special  = w_is_div & (w_div_zero | w_div_ovf);
  // func3[1] separates REM* from DIV*; INT_MIN/-1 quotient is op_a itself.
  assign w_spec_val = func3[1] ? (w_div_zero ? op_a : '0) : (w_div_zero ? '1 : op_a);

`ifdef MULDIV_FAST_MUL_EN
  logic [PW-1:0] w_fast_prod;
  assign w_fast_prod = PW'(w_a_mag) * PW'(w_b_mag);
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_load_hi   = '0;
    w_load_lo   = w_special ? w_spec_val : w_a_mag;
    w_acc_state = w_special ? MD_ST_FIX : (w_is_div ? MD_ST_DIV : MD_ST_MUL);
`ifdef MULDIV_FAST_MUL_EN
    if (!w_is_div) begin
      {w_load_hi, w_load_lo} = w_fast_prod;
      w_acc_state            = MD_ST_FIX;
    end
`endif
  end

  // ---------------- iteration datapath ----------------
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_last;
  logic [XLEN-1:0]  w_rem_nxt, w_quo_nxt;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_inc == LP_CNT_LAST);

`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
`endif

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .i_rem     (r_hi),
    .i_quo     (r_lo),
    .i_divisor (r_b),
    .o_rem     (w_rem_nxt),
    .o_quo     (w_quo_nxt)
  );

  // ---------------- sign fix-up ----------------
  logic [PW-1:0]   w_prod, w_prod_fix;
  logic [XLEN-1:0] w_div_raw, w_fix_result;

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg ? -w_prod : w_prod;
  assign w_div_raw  = r_f3[1] ? r_hi : r_lo;

  always_comb begin
    w_fix_result = '0;
    if (r_spec)              w_fix_result = r_lo;
    else if (r_f3[2])        w_fix_result = r_neg ? -w_div_raw : w_div_raw;
    else if (r_f3 == F3_MUL) w_fix_result = w_prod_fix[XLEN-1:0];
    else                     w_fix_result = w_prod_fix[PW-1:XLEN];
  end

  // ---------------- FSM ----------------
  // NOTE: datapath registers are reset along with control so a fresh part
  // never exposes X through result or the fix-up path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_f3     <= '0;
      r_neg    <= 1'b0;
      r_spec   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
    end else if (flush) begin
      r_state <= MD_ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      r_done <= 1'b0;
      case (r_state)
        MD_ST_IDLE, MD_ST_DONE: begin
          if (w_accept) begin
            r_state <= w_acc_state;
            r_busy  <= 1'b1;
            r_f3    <= func3;
            r_neg   <= w_neg;
            r_spec  <= w_special;
            r_hi    <= w_load_hi;
            r_lo    <= w_load_lo;
            r_b     <= w_b_mag;
            r_cnt   <= '0;
          end else begin
            r_state <= MD_ST_IDLE;
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        MD_ST_MUL: begin
          r_hi  <= w_mul_sum[XLEN:1];
          r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
          r_cnt <= w_cnt_inc;
          if (w_last) r_state <= MD_ST_FIX;
        end
`endif
        MD_ST_DIV: begin
          r_hi  <= w_rem_nxt;
          r_lo  <= w_quo_nxt;
          r_cnt <= w_cnt_inc;
          if (w_last) r_state <= MD_ST_FIX;
        end
        MD_ST_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= MD_ST_DONE;
        end
        default: begin
          r_state <= MD_ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign stall  = w_accept | r_busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// -----------------------------------------------------------------------------
// tb_muldiv_seq
//   Self-checking bench for muldiv_seq. Expected results are pushed into a
//   scoreboard queue when an op is issued; a negedge monitor pops and compares
//   result and latency whenever done is seen. Reference values come from
//   plain 64-bit arithmetic on the RV32M definitions.
//   Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_seq;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, stall, done;
  logic [31:0] result;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .func3  (func3),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    p  = '0;
    r  = '0;
    case (f3)
      F_MUL:    begin p = sa * sb; r = p[31:0]; end
      F_MULH:   begin p = sa * sb; r = p[63:32]; end
      F_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F_MULHU:  begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      F_DIV: begin
        if (b == 0) r = '1;
        else if (a == MIN && b == '1) r = MIN;
        else begin p = sa / sb; r = p[31:0]; end
      end
      F_DIVU: r = (b == 0) ? '1 : a / b;
      F_REM: begin
        if (b == 0) r = a;
        else if (a == MIN && b == '1) r = '0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Edges from the accepting edge (counted as 1) to the done edge.
  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2])
      return ((b == 0) || ((f3 == F_DIV || f3 == F_REM) && a == MIN && b == '1)) ? 2 : 34;
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 34;
`endif
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string name);
    exp_t e;
    e.res  = exp;
    e.acc  = cyc;
    e.lat  = ref_lat(f3, a, b);
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Called off-edge; returns #1 after the edge that samples the request.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp, input string name);
    start = 1'b1;
    func3 = f3;
    op_a  = a;
    op_b  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    func3 = 3'($urandom);
    op_a  = $urandom;
    op_b  = $urandom;
    if (push) push_exp(f3, a, b, exp, name);
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check({name, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string name);
    issue(f3, a, b, 1'b1, exp, name);
    wait_done(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int  stall_low;
    bit  seen;
    logic [2:0]  f3;
    logic [31:0] a, b;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 x -3 with stall tracking through the whole op
    start = 1'b1; func3 = F_MUL; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    #1;
    check("mul_stall_on_start", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
    stall_low = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!stall) stall_low++;
    end
    check("mul_done_seen", 32'(seen), 32'd1);
    check("mul_stall_gaps", 32'(stall_low), 32'd0);
    check("mul_stall_at_done", 32'(stall), 32'd0);

    // Directed results, including no-iteration special cases
    run(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
    run(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu_-1x2");
    run(F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_-7/2");
    run(F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_-7/2");
    run(F_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, "divu_by0");
    run(F_REMU,   32'd100,       32'd0,         32'd100,       "remu_by0");
    run(F_DIV,    MIN,           32'hFFFF_FFFF, MIN,           "div_ovf");
    run(F_REM,    MIN,           32'hFFFF_FFFF, 32'd0,         "rem_ovf");
    run(F_DIVU,   32'd100,       32'd7,         32'd14,        "divu_100/7");

    // Flush mid-divide: no done, result keeps 14
    @(negedge clk);
    issue(F_DIV, 32'd1000, 32'd7, 1'b0, 32'd0, "flushed");
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_result_kept", result, 32'd14);
    check("flush_stall", 32'(stall), 32'd0);
    // start together with flush is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; func3 = F_DIVU; op_a = 32'd9; op_b = 32'd3;
    #1;
    check("start_flush_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_dropped", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    run(F_DIVU, 32'd9, 32'd3, 32'd3, "divu_9/3");

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    issue(F_MUL, 32'd12345, 32'd678, 1'b0, 32'd0, "reset_victim");
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start while busy is ignored; start in the DONE cycle is accepted
    issue(F_MULH, 32'hFFFF_FFF0, 32'd3, 1'b1, 32'hFFFF_FFFF, "mulh_-16x3");
    repeat (3) @(negedge clk);
    start = 1'b1; func3 = F_DIVU; op_a = 32'd50; op_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("mulh_-16x3");
    issue(F_MUL, 32'd6, 32'd7, 1'b1, 32'd42, "mul_b2b");
    check("b2b_done_dropped", 32'(done), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done("mul_b2b");

    // Randomized ops against the reference model
    for (int n = 0; n < 60; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      run(f3, a, b, ref_model(f3, a, b), $sformatf("rand%0d_f%0d", n, f3));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
